// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory: packs little-endian words,
// writes them from BASE_ADDR upward and holds the core in reset until the checksum matches.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned MAX_WORDS = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_CSUM  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    localparam logic [31:0] L_MAX_32 = 32'(MAX_WORDS);
    localparam logic [15:0] L_MAX    = L_MAX_32[15:0];

    logic [2:0]  r_state;
    logic [15:0] r_len;
    logic [15:0] r_word_count;
    logic [31:0] r_word;
    logic [1:0]  r_idx;
    logic [7:0]  r_csum;
    logic [31:0] r_wa;
    logic [31:0] r_wd;

    logic        w_rx_ready;
    logic        w_accept;
    logic [15:0] w_len_full;
    logic [15:0] w_count_inc;

    // Every output is a pure decode of state or a register, so rx_valid/rx_data never reach an output.
    assign w_rx_ready  = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                         (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_accept    = rx_valid && w_rx_ready;
    assign w_len_full  = {rx_data, r_len[7:0]};
    assign w_count_inc = r_word_count + 16'd1;

    // NOTE: state registers use non-blocking assignments so every read in this block sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_word_count <= '0;
            r_word       <= '0;
            r_idx        <= '0;
            r_csum       <= '0;
            r_wa         <= '0;
            r_wd         <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state      <= S_LEN0;
                        r_word_count <= '0;
                        r_idx        <= '0;
                        r_csum       <= '0;
                        r_word       <= '0;
                    end
                end
                S_LEN0: begin
                    if (w_accept) begin
                        r_len[7:0] <= rx_data;
                        r_state    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (w_accept) begin
                        r_len[15:8] <= rx_data;
                        if ((w_len_full == 16'd0) || (w_len_full > L_MAX))
                            r_state <= S_ERR;
                        else
                            r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_word[{r_idx, 3'b000} +: 8] <= rx_data;
                        r_csum <= r_csum ^ rx_data;
                        r_idx  <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            // Address and data are captured here so they are stable throughout WRITE.
                            r_wd    <= {rx_data, r_word[23:0]};
                            r_wa    <= BASE_ADDR + {14'd0, r_word_count, 2'b00};
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_word_count <= w_count_inc;
                    r_state      <= (w_count_inc == r_len) ? S_CSUM : S_DATA;
                end
                S_CSUM: begin
                    if (w_accept)
                        r_state <= (rx_data == r_csum) ? S_DONE : S_ERR;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_ready   = w_rx_ready;
    assign we         = (r_state == S_WRITE);
    assign wa         = r_wa;
    assign wd         = r_wd;
    assign word_count = r_word_count;
    assign busy       = w_rx_ready || (r_state == S_WRITE);
    assign done       = (r_state == S_DONE);
    assign error      = (r_state == S_ERR);
    assign cpu_hold   = (r_state != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, back-pressure, bad checksum/length,
// gappy source and mid-load reset, against hand-computed write lists.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready, we, busy, done, error, cpu_hold;
    logic [31:0] wa, wd;
    logic [15:0] word_count;

    logic        rx_ready8, we8, busy8, done8, error8, cpu_hold8;
    logic [31:0] wa8, wd8;
    logic [15:0] word_count8;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int cyc_start = 0;
    int idle_cnt = 0;
    int ready_viol = 0;
    int we8_cnt = 0;
    logic [31:0] wr_wa[$];
    logic [31:0] wr_wd[$];

    logic [7:0]  nom [19];
    logic [31:0] exp_wa [4];
    logic [31:0] exp_wd [4];

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .we(we), .wa(wa), .wd(wd), .word_count(word_count),
        .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
    );

    imem_loader #(.MAX_WORDS(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready8), .we(we8), .wa(wa8), .wd(wd8), .word_count(word_count8),
        .busy(busy8), .done(done8), .error(error8), .cpu_hold(cpu_hold8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (we) begin
            wr_wa.push_back(wa);
            wr_wd.push_back(wd);
            if (rx_ready) ready_viol++;
        end
        if (we8) we8_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_we"}, 32'(we), 32'd0);
        chk({tag, "_wa"}, wa, 32'd0);
        chk({tag, "_wd"}, wd, 32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    task automatic do_start();
        @(negedge clk);
        rx_valid  = 1'b0;
        start     = 1'b1;
        cyc_start = cyc;
        wr_wa.delete();
        wr_wd.delete();
    endtask

    // Hold the byte while rx_ready is low; optionally insert idle cycles while it is high.
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        bit sent = 1'b0;
        for (int k = 0; k < 200 && !sent; k++) begin
            @(negedge clk);
            start   = 1'b0;
            rx_data = b;
            if (!rx_ready) begin
                rx_valid = 1'b1;
            end else if (int'($urandom_range(99)) < gap_pct) begin
                rx_valid = 1'b0;
                idle_cnt++;
            end else begin
                rx_valid = 1'b1;
                sent     = 1'b1;
            end
        end
        chk("byte_accepted", 32'(sent), 32'd1);
    endtask

    task automatic send_bytes(input int first, input int last, input int gap_pct);
        for (int i = first; i <= last; i++) send_byte(nom[i], gap_pct);
    endtask

    task automatic end_stream();
        bit seen = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (done || error) seen = 1'b1;
            else @(negedge clk);
        end
        chk("end_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_writes(input string tag, input int n);
        chk({tag, "_nwrites"}, 32'(wr_wa.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < wr_wa.size()) begin
                chk($sformatf("%s_wa%0d", tag, i), wr_wa[i], exp_wa[i]);
                chk($sformatf("%s_wd%0d", tag, i), wr_wd[i], exp_wd[i]);
            end
        end
    endtask

    initial begin
        nom = '{8'h04, 8'h00,
                8'h03, 8'hA3, 8'hC4, 8'hFF,
                8'h23, 8'hA4, 8'h64, 8'h00,
                8'h33, 8'hE2, 8'h62, 8'h00,
                8'hE3, 8'h0A, 8'h42, 8'hFE,
                8'h9E};
        exp_wa = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C};
        exp_wd = '{32'hFFC4_A303, 32'h0064_A423, 32'h0062_E233, 32'hFE42_0AE3};

        reset    = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        // Nominal load with rx_valid held high through every WRITE cycle.
        ready_viol = 0;
        do_start();
        send_bytes(0, 18, 0);
        end_stream();
        check_writes("nominal", 4);
        chk("nominal_done", 32'(done), 32'd1);
        chk("nominal_error", 32'(error), 32'd0);
        chk("nominal_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("nominal_word_count", 32'(word_count), 32'd4);
        chk("nominal_cycles", 32'(cyc - cyc_start), 32'd24);
        chk("bp_ready_in_write", 32'(ready_viol), 32'd0);
        chk("nominal_wa_held", wa, 32'h0000_100C);

        // Bad checksum.
        do_start();
        send_bytes(0, 17, 0);
        send_byte(8'h9F, 0);
        end_stream();
        check_writes("badcsum", 4);
        chk("badcsum_error", 32'(error), 32'd1);
        chk("badcsum_done", 32'(done), 32'd0);
        chk("badcsum_cpu_hold", 32'(cpu_hold), 32'd1);

        // Zero length.
        we8_cnt = 0;
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        end_stream();
        chk("len0_error", 32'(error), 32'd1);
        chk("len0_nwrites", 32'(wr_wa.size()), 32'd0);
        chk("len0_error8", 32'(error8), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);

        // Length 9 against MAX_WORDS=8; the default instance accepts it.
        do_start();
        send_byte(8'h09, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("len9_error8", 32'(error8), 32'd1);
        chk("len9_done8", 32'(done8), 32'd0);
        chk("len9_we8", 32'(we8_cnt), 32'd0);
        chk("len9_busy_default", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Gappy source.
        idle_cnt = 0;
        do_start();
        send_bytes(0, 18, 30);
        end_stream();
        check_writes("gappy", 4);
        chk("gappy_done", 32'(done), 32'd1);
        chk("gappy_cycles", 32'(cyc - cyc_start), 32'(24 + idle_cnt));

        // Reset after the second payload word has been written.
        do_start();
        send_bytes(0, 9, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("midrst_nwrites", 32'(wr_wa.size()), 32'd2);
        reset = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        do_start();
        send_bytes(0, 18, 0);
        end_stream();
        check_writes("reload", 4);
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_word_count", 32'(word_count), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
